// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: IDLE/RUN/PAUSE FSM, tick prescaler, cascaded BCD digits,
// lap freeze of the displayed value and sticky overflow.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int NDIG     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*NDIG-1:0]   digits,
  output logic                running,
  output logic                frozen,
  output logic                overflow
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       presc, presc_nxt;
  logic [4*NDIG-1:0]   count, count_nxt, count_inc;
  logic [4*NDIG-1:0]   lap_reg, lap_nxt;
  logic                frozen_nxt, overflow_nxt;
  logic                tick;
  logic [NDIG:0]       carry;

  // One decade step; anything at or above 9 wraps so digits stay in 0..9.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  assign tick = (state == RUN) && (presc == PW'(TICK_DIV - 1));

  // Carry enters digit i only when every lower digit sits at 9; all digits update together.
  always_comb begin
    carry     = '0;
    count_inc = count;
    carry[0]  = tick;
    for (int i = 0; i < NDIG; i++) begin
      carry[i+1] = carry[i] && (count[4*i +: 4] == 4'd9);
      if (carry[i]) count_inc[4*i +: 4] = bcd_inc(count[4*i +: 4]);
    end
  end

  always_comb begin
    state_nxt    = state;
    presc_nxt    = presc;
    count_nxt    = count;
    lap_nxt      = lap_reg;
    frozen_nxt   = frozen;
    overflow_nxt = overflow;
    if (clear) begin
      state_nxt    = IDLE;
      presc_nxt    = '0;
      count_nxt    = '0;
      lap_nxt      = '0;
      frozen_nxt   = 1'b0;
      overflow_nxt = 1'b0;
    end else begin
      if (state == RUN) begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        count_nxt = count_inc;
        if (carry[NDIG]) overflow_nxt = 1'b1;
      end
      case (state)
        IDLE:  if (start_stop) state_nxt = RUN;
        RUN: begin
          if (start_stop) begin
            state_nxt = PAUSE;
          end else if (lap) begin
            frozen_nxt = !frozen;
            // Capture the value on display when lap is pressed.
            if (!frozen) lap_nxt = count;
          end
        end
        PAUSE: if (start_stop) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      count    <= '0;
      lap_reg  <= '0;
      frozen   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      count    <= count_nxt;
      lap_reg  <= lap_nxt;
      frozen   <= frozen_nxt;
      overflow <= overflow_nxt;
    end
  end

  assign running = (state == RUN);
  assign digits  = frozen ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (TICK_DIV=2, NDIG=2): directed scenarios plus random
// pulses, compared against an integer-valued stopwatch model.
module tb_stopwatch_ctrl;

  localparam int TD   = 2;
  localparam int ND   = 2;
  localparam int MAXV = 100;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_stop = 1'b0;
  logic            clear = 1'b0;
  logic            lap = 1'b0;
  logic [4*ND-1:0] digits;
  logic            running, frozen, overflow;

  int errors = 0;
  int checks = 0;

  int m_mode = M_IDLE;
  int m_presc = 0;
  int m_cnt = 0;
  int m_lapv = 0;
  bit m_frz = 0;
  bit m_ov = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .NDIG(ND)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .digits(digits), .running(running), .frozen(frozen), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4*ND+2:0] exp_vec();
    return {to_bcd(m_frz ? m_lapv : m_cnt), (m_mode == M_RUN), m_frz, m_ov};
  endfunction

  // Stopwatch as a person would describe it: an integer that counts every TD cycles of run time.
  task automatic model_edge(input bit ss, input bit cl, input bit lp, input bit r);
    int old;
    old = m_cnt;
    if (r || cl) begin
      m_mode = M_IDLE; m_presc = 0; m_cnt = 0; m_lapv = 0; m_frz = 0; m_ov = 0;
    end else begin
      if (m_mode == M_RUN) begin
        m_presc++;
        if (m_presc == TD) begin
          m_presc = 0;
          m_cnt++;
          if (m_cnt == MAXV) begin m_cnt = 0; m_ov = 1; end
        end
      end
      if (m_mode == M_IDLE && ss) m_mode = M_RUN;
      else if (m_mode == M_RUN && ss) m_mode = M_PAUSE;
      else if (m_mode == M_PAUSE && ss) m_mode = M_RUN;
      else if (m_mode == M_RUN && lp) begin
        if (!m_frz) m_lapv = old;
        m_frz = !m_frz;
      end
    end
  endtask

  task automatic step(input bit ss, input bit cl, input bit lp, input bit r);
    start_stop = ss; clear = cl; lap = lp; rst = r;
    @(posedge clk);
    model_edge(ss, cl, lp, r);
    #1;
    start_stop = 0; clear = 0; lap = 0; rst = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, i < 2);
      if ({digits, running, frozen, overflow} !== 11'h0) begin
        errors++;
        $display("FAIL reset cyc %0d: got %h required 000", i, {digits, running, frozen, overflow});
      end
      checks++;
    end
  endtask

  task automatic test_count();
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 0);
      if ({digits, running, frozen, overflow} !== exp_vec()) begin
        errors++;
        $display("FAIL count step %0d: got %h required %h", i, {digits, running, frozen, overflow}, exp_vec());
      end
      checks++;
      if (i == 2 && digits !== 8'h01) begin
        errors++;
        $display("FAIL first_tick: got %h required 01", digits);
      end
      if (i == 2) checks++;
    end
    if (digits !== 8'h10 || running !== 1'b1) begin
      errors++;
      $display("FAIL count_end: got %h run %b required 10 run 1", digits, running);
    end
    checks++;
  endtask

  task automatic test_pause();
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 300 && m_cnt != 37; i++) step(0, 0, 0, 0);
    if (digits !== 8'h37) begin
      errors++;
      $display("FAIL pause_reach: got %h required 37", digits);
    end
    checks++;
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      if (digits !== 8'h37 || running !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold %0d: got %h run %b required 37 run 0", i, digits, running);
      end
      checks++;
    end
    step(1, 0, 0, 0);
    if (digits !== 8'h37) begin
      errors++;
      $display("FAIL resume_edge: got %h required 37", digits);
    end
    checks++;
    step(0, 0, 0, 0);
    if (digits !== 8'h38) begin
      errors++;
      $display("FAIL resume_phase: got %h required 38", digits);
    end
    checks++;
  endtask

  task automatic test_overflow();
    bit seen;
    seen = 0;
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 1; i <= 200; i++) begin
      step(0, 0, 0, 0);
      if ({digits, running, frozen, overflow} !== exp_vec()) begin
        errors++;
        $display("FAIL overflow step %0d: got %h required %h", i, {digits, running, frozen, overflow}, exp_vec());
      end
      checks++;
      if (overflow === 1'b1) seen = 1;
    end
    if (!seen || digits !== 8'h00 || overflow !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL overflow_end: got %h ov %b run %b required 00 ov 1 run 1", digits, overflow, running);
    end
    checks++;
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
    if (digits !== 8'h01 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %h ov %b required 01 ov 1", digits, overflow);
    end
    checks++;
  endtask

  task automatic test_lap();
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 300 && m_cnt != 12; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      if (digits !== 8'h12 || frozen !== 1'b1) begin
        errors++;
        $display("FAIL lap_hold %0d: got %h frz %b required 12 frz 1", i, digits, frozen);
      end
      checks++;
    end
    step(0, 0, 1, 0);
    if ({digits, running, frozen, overflow} !== exp_vec() || frozen !== 1'b0) begin
      errors++;
      $display("FAIL lap_release: got %h required %h", {digits, running, frozen, overflow}, exp_vec());
    end
    checks++;
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    if (frozen !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL lap_in_pause: frz %b run %b required frz 0 run 0", frozen, running);
    end
    checks++;
  endtask

  task automatic test_clear_rst();
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    if ({digits, running, frozen, overflow} !== 11'h0) begin
      errors++;
      $display("FAIL clear_wins: got %h required 000", {digits, running, frozen, overflow});
    end
    checks++;
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    if ({digits, running, frozen, overflow} !== 11'h0) begin
      errors++;
      $display("FAIL rst_mid: got %h required 000", {digits, running, frozen, overflow});
    end
    checks++;
  endtask

  task automatic test_random();
    bit ss, cl, lp, r;
    for (int i = 0; i < 600; i++) begin
      ss = ($urandom_range(15) == 0);
      cl = ($urandom_range(80) == 0);
      lp = ($urandom_range(9) == 0);
      r  = ($urandom_range(250) == 0);
      step(ss, cl, lp, r);
      if ({digits, running, frozen, overflow} !== exp_vec()) begin
        errors++;
        $display("FAIL random %0d: got %h required %h", i, {digits, running, frozen, overflow}, exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_overflow();
    test_lap();
    test_clear_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
